// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; predicts next fetch PC combinationally.
// Optional performance counters are built in when BP_PERF_CNT_EN is defined.
module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] lk_pc,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_is_jump,
  input  logic        upd_mispredict,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned TagLo   = IDX_W + 2;
  localparam int unsigned TagHi   = IDX_W + 2 + TAG_W - 1;

  logic             valid_q  [Entries];
  logic [TAG_W-1:0] tag_q    [Entries];
  logic [31:0]      target_q [Entries];
  logic [1:0]       ctr_q    [Entries];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, accept;
  logic             upd_write, upd_alloc, upd_tgt_write;
  logic [1:0]       upd_ctr_cur, upd_ctr_new;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[TagHi:TagLo];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[TagHi:TagLo];
  assign accept  = rdy & upd_valid;

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_pc    = lk_pc + 32'd4;
    pred_taken = 1'b0;
    if (lk_hit && ctr_q[lk_idx][1]) begin
      pred_pc    = target_q[lk_idx];
      pred_taken = 1'b1;
    end
  end

  always_comb begin
    upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_cur   = ctr_q[upd_idx];
    upd_ctr_new   = upd_ctr_cur;
    upd_write     = 1'b0;
    upd_alloc     = 1'b0;
    upd_tgt_write = 1'b0;
    if (upd_hit) begin
      upd_write = 1'b1;
      if (upd_is_jump) begin
        upd_ctr_new   = 2'b11;
        upd_tgt_write = 1'b1;
      end else if (upd_taken) begin
        upd_ctr_new   = (upd_ctr_cur == 2'b11) ? 2'b11 : upd_ctr_cur + 2'd1;
        upd_tgt_write = 1'b1;
      end else begin
        upd_ctr_new = (upd_ctr_cur == 2'b00) ? 2'b00 : upd_ctr_cur - 2'd1;
      end
    end else if (upd_taken || upd_is_jump) begin
      // Miss on a redirect allocates, evicting any aliased entry.
      upd_write     = 1'b1;
      upd_alloc     = 1'b1;
      upd_tgt_write = 1'b1;
      upd_ctr_new   = upd_is_jump ? 2'b11 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (accept && upd_write) begin
      ctr_q[upd_idx] <= upd_ctr_new;
      if (upd_tgt_write) target_q[upd_idx] <= upd_target;
      if (upd_alloc) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branches_q, mispredicts_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (accept) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (upd_mispredict && (mispredicts_q != 32'hFFFF_FFFF)) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign perf_branches    = branches_q;
  assign perf_mispredicts = mispredicts_q;
`else
  assign perf_branches    = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

  // Word-offset bits never index the table; mispredict only feeds the optional counters.
  logic unused_bits;
  assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0], upd_mispredict};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default IDX_W=6, TAG_W=24).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] lk_pc, pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken, upd_is_jump, upd_mispredict;
  logic [31:0] perf_branches, perf_mispredicts;

  int tests = 0;
  int fails = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .lk_pc            (lk_pc),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_taken        (upd_taken),
    .upd_is_jump      (upd_is_jump),
    .upd_mispredict   (upd_mispredict),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  // Present one update for one clock edge; returns at posedge+1.
  task automatic apply_update(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic jp, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
    upd_taken = tk; upd_is_jump = jp; upd_mispredict = mp;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_is_jump = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic check_lookup(input string name, input logic [31:0] pc,
                              input logic [31:0] exp_pc, input logic exp_tk);
    lk_pc = pc; #1;
    tests++;
    if (pred_pc !== exp_pc || pred_taken !== exp_tk) begin
      fails++;
      $display("FAIL %s: got pred_pc=%h taken=%b, expected pred_pc=%h taken=%b",
               name, pred_pc, pred_taken, exp_pc, exp_tk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_lookup("reset_lookup", 32'h0000_1000, 32'h0000_1004, 1'b0);
    check_lookup("reset_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
    tests++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      fails++;
      $display("FAIL reset_perf: got %0d/%0d, expected 0/0", perf_branches, perf_mispredicts);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_taken_alloc;
    apply_update(32'h1000, 32'h0F00, 1'b1, 1'b0, 1'b0);
    check_lookup("alloc_taken", 32'h1000, 32'h0F00, 1'b1);
    apply_update(32'h1000, 32'h0F00, 1'b1, 1'b0, 1'b0);
    check_lookup("second_taken", 32'h1000, 32'h0F00, 1'b1);
  endtask

  task automatic test_hysteresis;
    apply_update(32'h1000, 32'h0BAD, 1'b0, 1'b0, 1'b1);
    check_lookup("nt1_ctr10", 32'h1000, 32'h0F00, 1'b1);
    apply_update(32'h1000, 32'h0BAD, 1'b0, 1'b0, 1'b1);
    check_lookup("nt2_ctr01", 32'h1000, 32'h1004, 1'b0);
    apply_update(32'h1000, 32'h0BAD, 1'b0, 1'b0, 1'b0);
    check_lookup("nt3_ctr00", 32'h1000, 32'h1004, 1'b0);
    apply_update(32'h1000, 32'h0E00, 1'b1, 1'b0, 1'b0);
    check_lookup("tk_ctr01", 32'h1000, 32'h1004, 1'b0);
    apply_update(32'h1000, 32'h0E00, 1'b1, 1'b0, 1'b0);
    check_lookup("tk_ctr10_newtgt", 32'h1000, 32'h0E00, 1'b1);
  endtask

  task automatic test_miss_jump_alias;
    apply_update(32'h2000, 32'h2200, 1'b0, 1'b0, 1'b0);
    check_lookup("nt_miss_noalloc", 32'h2000, 32'h2004, 1'b0);
    apply_update(32'h3000, 32'h3400, 1'b0, 1'b1, 1'b0);
    check_lookup("jal_alloc", 32'h3000, 32'h3400, 1'b1);
    apply_update(32'h3000, 32'h3400, 1'b0, 1'b0, 1'b0);
    check_lookup("jal_ctr11_nt", 32'h3000, 32'h3400, 1'b1);
    apply_update(32'h3100, 32'h5000, 1'b1, 1'b0, 1'b0);
    check_lookup("alias_evicted", 32'h3000, 32'h3004, 1'b0);
    check_lookup("alias_new", 32'h3100, 32'h5000, 1'b1);
    apply_update(32'h3100, 32'h5000, 1'b0, 1'b0, 1'b0);
    apply_update(32'h3100, 32'h5100, 1'b1, 1'b1, 1'b0);
    apply_update(32'h3100, 32'h5000, 1'b0, 1'b0, 1'b0);
    check_lookup("hit_jump_sets11", 32'h3100, 32'h5100, 1'b1);
  endtask

  task automatic test_simultaneous;
    upd_valid = 1'b1; upd_pc = 32'h4000; upd_target = 32'h4800;
    upd_taken = 1'b1; upd_is_jump = 1'b0; upd_mispredict = 1'b0;
    check_lookup("same_cycle_old", 32'h4000, 32'h4004, 1'b0);
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_taken = 1'b0;
    check_lookup("next_cycle_new", 32'h4000, 32'h4800, 1'b1);
  endtask

  task automatic test_stall;
    rdy = 1'b0;
    apply_update(32'h6000, 32'h6600, 1'b1, 1'b0, 1'b0);
    apply_update(32'h4000, 32'h4800, 1'b0, 1'b0, 1'b0);
    apply_update(32'h4000, 32'h4800, 1'b0, 1'b0, 1'b0);
    rdy = 1'b1;
    check_lookup("stall_no_alloc", 32'h6000, 32'h6004, 1'b0);
    check_lookup("stall_no_train", 32'h4000, 32'h4800, 1'b1);
  endtask

  task automatic test_reset_midrun;
    rst = 1'b0;
    apply_update(32'h7000, 32'h7700, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    check_lookup("rst_drops_update", 32'h7000, 32'h7004, 1'b0);
    check_lookup("rst_invalidates", 32'h1000, 32'h1004, 1'b0);
  endtask

  task automatic test_perf;
    logic [31:0] exp_b, exp_m;
`ifdef BP_PERF_CNT_EN
    exp_b = 32'd5; exp_m = 32'd2;
`else
    exp_b = 32'd0; exp_m = 32'd0;
`endif
    apply_update(32'h8000, 32'h8800, 1'b1, 1'b0, 1'b1);
    apply_update(32'h8000, 32'h8800, 1'b0, 1'b0, 1'b0);
    apply_update(32'h9000, 32'h9900, 1'b0, 1'b1, 1'b1);
    rdy = 1'b0;
    apply_update(32'h9000, 32'h9900, 1'b0, 1'b1, 1'b1);
    rdy = 1'b1;
    apply_update(32'hA000, 32'hA000, 1'b0, 1'b0, 1'b0);
    apply_update(32'h8000, 32'h8800, 1'b1, 1'b0, 1'b0);
    tests++;
    if (perf_branches !== exp_b) begin
      fails++;
      $display("FAIL perf_branches: got %0d, expected %0d", perf_branches, exp_b);
    end
    tests++;
    if (perf_mispredicts !== exp_m) begin
      fails++;
      $display("FAIL perf_mispredicts: got %0d, expected %0d", perf_mispredicts, exp_m);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tests++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      fails++;
      $display("FAIL perf_after_reset: got %0d/%0d, expected 0/0",
               perf_branches, perf_mispredicts);
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; lk_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_is_jump = 1'b0; upd_mispredict = 1'b0;
    test_reset();
    test_taken_alloc();
    test_hysteresis();
    test_miss_jump_alias();
    test_simultaneous();
    test_stall();
    test_reset_midrun();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end counterpart to the EX-stage branch resolution path. It consumes EX's resolved-branch report (pc, target, taken, mispredict) and trains a direct-mapped BTB with 2-bit saturating counters.
- It supplies the predicted next PC to the PC/IF stage every cycle.
- The lookup is combinational on registered table state; updates commit on the clock edge.

Parameters:
- IDX_W, 6: index width; the BTB holds 2^IDX_W entries.
- TAG_W, 24: stored tag width, taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2]; must satisfy IDX_W+2+TAG_W <= 32.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, synchronous, active-low.
- rdy, input, 1: global ready; when low, no table or counter state changes.
- lk_pc, input, 32: PC being fetched (lookup address).
- pred_pc, output, 32: predicted next PC.
- pred_taken, output, 1: prediction is a taken redirect.
- upd_valid, input, 1: EX reports a resolved branch or jump this cycle.
- upd_pc, input, 32: PC of the resolved instruction.
- upd_target, input, 32: resolved target (pc+imm, or the JALR target with bit 0 cleared).
- upd_taken, input, 1: branch actually taken.
- upd_is_jump, input, 1: JAL/JALR (always taken).
- upd_mispredict, input, 1: EX detected a wrong next PC.
- perf_branches, output, 32: resolved-update count (see Optional Feature).
- perf_mispredicts, output, 32: mispredict count (see Optional Feature).

Behaviour:
- Entry fields: valid, tag[TAG_W], target[32], ctr[2]. idx(x) = x[IDX_W+1:2]; tag(x) = x[IDX_W+2+TAG_W-1:IDX_W+2].
- Reset (rst==0 at posedge): all valid=0, ctr=2'b01, target=0, tag=0; perf counters=0.
  - Outputs during reset follow the lookup rule. With all entries invalid: pred_pc=lk_pc+4, pred_taken=0.
- Lookup, combinational, zero latency:
  - hit = valid[idx(lk_pc)] && tag match.
  - If hit && ctr[1]: pred_pc=target, pred_taken=1.
  - Else: pred_pc=lk_pc+4 (32-bit wrap), pred_taken=0.
- Update, at posedge when rst==1 && rdy==1 && upd_valid==1, on entry e=idx(upd_pc):
  - Hit, upd_is_jump: ctr=2'b11, target=upd_target.
  - Hit, branch taken: ctr=sat_inc(ctr), target=upd_target.
  - Hit, branch not taken: ctr=sat_dec(ctr); target unchanged.
  - Miss, and (taken or jump): allocate/overwrite. valid=1, tag=tag(upd_pc), target=upd_target. ctr=2'b11 for a jump, 2'b10 for a taken branch.
  - Miss and not taken: no change (no allocation).
- Saturation: the counter never wraps. 2'b11 plus one stays 2'b11; 2'b00 minus one stays 2'b00.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents (no bypass). The new contents are visible on the cycle after the edge.
- upd_valid while rdy==0: the update is dropped. EX holds its outputs while stalled, so the update is re-presented.
- upd_mispredict is informational only; it does not alter training. Training is fully determined by taken/jump/target.
- Aliasing: a different tag at the same index counts as a miss. An allocation replaces the old entry.
- Reset asserted mid-run: all entries are invalidated on that edge, and any update presented in the same cycle is discarded.

Optional Feature:
- Macro BP_PERF_CNT_EN.
- Defined:
  - perf_branches increments on every accepted update.
  - perf_mispredicts increments on every accepted update with upd_mispredict==1.
  - Both are 32-bit and saturate at 32'hFFFFFFFF (no wrap).
  - Both clear on reset.
- Undefined: both ports remain and are constant 0; no counter flops are instantiated.

Test Plan:
- Reset, then lk_pc=0x00001000 -> pred_pc=0x00001004, pred_taken=0. Also check lk_pc=0xFFFFFFFC -> pred_pc=0x00000000.
- Taken branch allocation and saturation:
  - Update pc=0x1000, target=0x0F00, taken=1, jump=0 -> next cycle lk_pc=0x1000 gives pred_pc=0x0F00, pred_taken=1.
  - A second taken update -> ctr=11.
- Hysteresis:
  - From ctr=11, two not-taken updates -> ctr=01; lookup gives 0x1004, pred_taken=0.
  - A third not-taken update holds ctr=00.
  - One taken update -> ctr=01, still predicting not taken.
- Not-taken miss, jumps, aliasing:
  - Not-taken update at pc=0x2000 on an empty entry -> lookup of 0x2000 still misses.
  - JAL update at pc=0x3000, target=0x3400 -> ctr=11, predicts 0x3400.
  - Update at pc=0x3000+(4<<IDX_W) -> lookup of 0x3000 misses.
- Simultaneous lookup and update, plus stall:
  - Update and lookup of the same idx in one cycle -> lookup shows old value; the next cycle shows the new one.
  - Update with rdy=0 -> no change.
- BP_PERF_CNT_EN defined: 5 updates, 2 with mispredict=1 -> perf_branches=5, perf_mispredicts=2. After reset, both are 0. Undefined: both stay 0 throughout.
